// File: rtl/power_accum.sv
// power_accum
//   Non-coherent integrator placed after the magnitude-squared stage.
//   Per-bin power (4 lanes per bin, up to two bins per beat) is summed over
//   2^FRAMES_LOG2 frames. The rounded per-bin average is then streamed out
//   in bin order, and each accumulator is cleared as it is read.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous active-high reset
//   in_valid       beat qualifier
//   in_index_col1  bin of in_col1
//   in_index_col2  bin of in_col2 (used only when in_index_col1 >= 2 and
//                  in_index_col2 differs from in_index_col1)
//   in_col1/2      4 packed unsigned power lanes, lane 0 in the LSBs
//   err_clr        synchronous clear of the sticky error flags
//   out_valid      out_index/out_data valid (one bin per cycle during a dump)
//   out_last       high together with the final bin of a dump
//   out_index      bin being output
//   out_data       rounded average per lane (holds when out_valid is low)
//   frame_cnt      frames closed in the current period
//   drop_err       sticky: a beat arrived while dumping
//   idx_err        sticky: an out-of-range index was used
module power_accum #(
  parameter int DATA_WIDTH  = 52,
  parameter int INDEX_WIDTH = 11,
  parameter int NUM_BINS    = 16,
  parameter int FRAMES_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [INDEX_WIDTH-1:0]  in_index_col1,
  input  logic [INDEX_WIDTH-1:0]  in_index_col2,
  input  logic [4*DATA_WIDTH-1:0] in_col1,
  input  logic [4*DATA_WIDTH-1:0] in_col2,
  input  logic                    err_clr,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [INDEX_WIDTH-1:0]  out_index,
  output logic [4*DATA_WIDTH-1:0] out_data,
  output logic [FRAMES_LOG2-1:0]  frame_cnt,
  output logic                    drop_err,
  output logic                    idx_err
);

  // The sum of 2^FRAMES_LOG2 DATA_WIDTH-bit values always fits in ACC_WIDTH.
  localparam int ACC_WIDTH = DATA_WIDTH + FRAMES_LOG2;
  localparam int PTR_WIDTH = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX   = INDEX_WIDTH'(NUM_BINS - 1);
  localparam logic [PTR_WIDTH-1:0]   LAST_PTR   = PTR_WIDTH'(NUM_BINS - 1);
  localparam logic [FRAMES_LOG2-1:0] FRAME_MAX  = '1;
  localparam logic [ACC_WIDTH:0]     ROUND_BIAS = (ACC_WIDTH + 1)'(1) << (FRAMES_LOG2 - 1);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_DUMP = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [PTR_WIDTH-1:0]    r_dump_ptr;
  logic [FRAMES_LOG2-1:0]  r_frame_cnt;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic [INDEX_WIDTH-1:0]  r_out_index;
  logic [4*DATA_WIDTH-1:0] r_out_data;
  logic                    r_drop_err;
  logic                    r_idx_err;

  logic                    w_in_acc;
  logic                    w_in_dump;
  logic                    w_beat;
  logic                    w_idx1_ok;
  logic                    w_idx2_ok;
  logic                    w_col2_used;
  logic                    w_take1;
  logic                    w_take2;
  logic                    w_idx_bad;
  logic                    w_close;
  logic                    w_last_frame;
  logic                    w_dump_end;
  logic [4*DATA_WIDTH-1:0] w_dump_data;
  logic [ACC_WIDTH-1:0]    w_acc [NUM_BINS][4];

  // ---------------------------------------------------------------------
  // Beat decode
  // ---------------------------------------------------------------------
  assign w_in_acc  = (r_state == S_ACC);
  assign w_in_dump = (r_state == S_DUMP);
  assign w_beat    = in_valid & w_in_acc;

  assign w_idx1_ok   = (in_index_col1 <= LAST_IDX);
  assign w_idx2_ok   = (in_index_col2 <= LAST_IDX);
  // Bins 0 and 1 never carry a second column; a duplicate bin in col2 is
  // also ignored so each bin is added at most once per beat.
  assign w_col2_used = (in_index_col1 >= INDEX_WIDTH'(2)) && (in_index_col2 != in_index_col1);

  assign w_take1   = w_beat & w_idx1_ok;
  assign w_take2   = w_beat & w_col2_used & w_idx2_ok;
  assign w_idx_bad = w_beat & (~w_idx1_ok | (w_col2_used & ~w_idx2_ok));

  // A frame closes when the highest bin is actually accumulated.
  assign w_close      = (w_take1 & (in_index_col1 == LAST_IDX)) |
                        (w_take2 & (in_index_col2 == LAST_IDX));
  assign w_last_frame = w_close & (r_frame_cnt == FRAME_MAX);
  assign w_dump_end   = w_in_dump & (r_dump_ptr == LAST_PTR);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACC:   if (w_last_frame) w_state_next = S_DUMP;
      S_DUMP:  if (w_dump_end)   w_state_next = S_ACC;
      default: w_state_next = S_ACC;
    endcase
  end

  // ---------------------------------------------------------------------
  // Accumulator array, one register per bin and lane
  // ---------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
    logic w_hit1;
    logic w_hit2;
    logic w_clear;

    assign w_hit1  = w_take1 & (in_index_col1 == INDEX_WIDTH'(gi));
    assign w_hit2  = w_take2 & (in_index_col2 == INDEX_WIDTH'(gi));
    assign w_clear = w_in_dump & (r_dump_ptr == PTR_WIDTH'(gi));

    for (genvar gl = 0; gl < 4; gl++) begin : g_lane
      logic [ACC_WIDTH-1:0] r_acc;
      logic [ACC_WIDTH-1:0] w_add;

      // col1 and col2 never target the same bin, so the hits are exclusive.
      always_comb begin
        w_add = '0;
        if (w_hit1) begin
          w_add = ACC_WIDTH'(in_col1[gl*DATA_WIDTH +: DATA_WIDTH]);
        end else if (w_hit2) begin
          w_add = ACC_WIDTH'(in_col2[gl*DATA_WIDTH +: DATA_WIDTH]);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc <= '0;
        end else if (w_clear) begin
          r_acc <= '0;
        end else if (w_hit1 | w_hit2) begin
          r_acc <= r_acc + w_add;
        end
      end

      assign w_acc[gi][gl] = r_acc;
    end
  end

  // ---------------------------------------------------------------------
  // Dump read path: round-half-up average of the bin under the pointer
  // ---------------------------------------------------------------------
  for (genvar gl = 0; gl < 4; gl++) begin : g_avg
    logic [ACC_WIDTH-1:0] w_sel;
    logic [ACC_WIDTH:0]   w_rsum;
    logic                 w_unused_bits;

    assign w_sel  = w_acc[r_dump_ptr][gl];
    assign w_rsum = {1'b0, w_sel} + ROUND_BIAS;
    assign w_dump_data[gl*DATA_WIDTH +: DATA_WIDTH] = w_rsum[FRAMES_LOG2 +: DATA_WIDTH];
    // Fraction bits and the carry bit (always zero after the shift) are dropped.
    assign w_unused_bits = ^{w_rsum[ACC_WIDTH], w_rsum[FRAMES_LOG2-1:0]};
  end

  // ---------------------------------------------------------------------
  // Dump pointer, frame counter, output registers, sticky flags
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dump_ptr <= '0;
    end else if (w_in_dump && !w_dump_end) begin
      r_dump_ptr <= r_dump_ptr + 1'b1;
    end else begin
      r_dump_ptr <= '0;
    end
  end

  // The counter stays at its maximum for the whole dump and wraps at its end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= '0;
    end else if (w_dump_end) begin
      r_frame_cnt <= '0;
    end else if (w_close && (r_frame_cnt != FRAME_MAX)) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_index <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      if (w_in_dump) begin
        r_out_valid <= 1'b1;
        r_out_last  <= (r_dump_ptr == LAST_PTR);
        r_out_index <= INDEX_WIDTH'(r_dump_ptr);
        r_out_data  <= w_dump_data;
      end
    end
  end

  // Set has priority over err_clr in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_err <= 1'b0;
      r_idx_err  <= 1'b0;
    end else begin
      if (in_valid && w_in_dump) begin
        r_drop_err <= 1'b1;
      end else if (err_clr) begin
        r_drop_err <= 1'b0;
      end
      if (w_idx_bad) begin
        r_idx_err <= 1'b1;
      end else if (err_clr) begin
        r_idx_err <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_index = r_out_index;
  assign out_data  = r_out_data;
  assign frame_cnt = r_frame_cnt;
  assign drop_err  = r_drop_err;
  assign idx_err   = r_idx_err;

endmodule

// File: tb/tb_power_accum.sv
// tb_power_accum
//   Directed bench for power_accum with NUM_BINS=4 and FRAMES_LOG2=1, so each
//   period is two frames and each output is (a + b + 1) >> 1 per lane.
//   Lanes usually carry base, base+1, base+2, base+3, so that a swapped or
//   broken lane shows up. Inputs are driven on the falling edge, and outputs
//   are checked on the falling edge.
module tb_power_accum;

  localparam int DW = 52;
  localparam int IW = 11;
  localparam int NB = 4;
  localparam int FL = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [IW-1:0]   in_index_col1;
  logic [IW-1:0]   in_index_col2;
  logic [4*DW-1:0] in_col1;
  logic [4*DW-1:0] in_col2;
  logic            err_clr;
  logic            out_valid;
  logic            out_last;
  logic [IW-1:0]   out_index;
  logic [4*DW-1:0] out_data;
  logic [FL-1:0]   frame_cnt;
  logic            drop_err;
  logic            idx_err;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0]   max_lane;
  logic [4*DW-1:0] max_all;

  power_accum #(
    .DATA_WIDTH (DW),
    .INDEX_WIDTH(IW),
    .NUM_BINS   (NB),
    .FRAMES_LOG2(FL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_index_col1(in_index_col1),
    .in_index_col2(in_index_col2),
    .in_col1      (in_col1),
    .in_col2      (in_col2),
    .err_clr      (err_clr),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_index    (out_index),
    .out_data     (out_data),
    .frame_cnt    (frame_cnt),
    .drop_err     (drop_err),
    .idx_err      (idx_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4*DW-1:0] lanes(input logic [DW-1:0] b);
    return {b + 52'd3, b + 52'd2, b + 52'd1, b};
  endfunction

  function automatic logic [4*DW-1:0] pack4(input logic [DW-1:0] a0, input logic [DW-1:0] a1,
                                            input logic [DW-1:0] a2, input logic [DW-1:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [4*DW-1:0] obs, input logic [4*DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; the beat is sampled on the rising edge in between.
  task automatic beat(input logic [IW-1:0] i1, input logic [IW-1:0] i2,
                      input logic [4*DW-1:0] c1, input logic [4*DW-1:0] c2);
    in_valid      = 1'b1;
    in_index_col1 = i1;
    in_index_col2 = i2;
    in_col1       = c1;
    in_col2       = c2;
    @(negedge clk);
    in_valid = 1'b0;
    in_col1  = '0;
    in_col2  = '0;
  endtask

  // Called right after the closing beat of a period. The task optionally
  // injects a beat for bin 2 (value 50) that is sampled on dump edge drop_at.
  task automatic check_dump(input logic [4*DW-1:0] e0, input logic [4*DW-1:0] e1,
                            input logic [4*DW-1:0] e2, input logic [4*DW-1:0] e3,
                            input int drop_at);
    logic [4*DW-1:0] e;
    chk1("dump_latency_valid", out_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (drop_at == k + 1) begin
        in_valid      = 1'b1;
        in_index_col1 = 11'd2;
        in_index_col2 = 11'd2;
        in_col1       = lanes(52'd50);
        in_col2       = '0;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_col1  = '0;
      case (k)
        0:       e = e0;
        1:       e = e1;
        2:       e = e2;
        default: e = e3;
      endcase
      chk1("dump_valid", out_valid, 1'b1);
      chki("dump_index", out_index, IW'(k));
      chkd("dump_data", out_data, e);
      chk1("dump_last", out_last, (k == 3));
    end
    chk1("dump_frame_cnt_zero", frame_cnt, 1'b0);
  endtask

  initial begin
    max_lane      = '1;
    max_all       = {4{max_lane}};
    rst           = 1'b1;
    in_valid      = 1'b0;
    in_index_col1 = '0;
    in_index_col2 = '0;
    in_col1       = '0;
    in_col2       = '0;
    err_clr       = 1'b0;

    // Reset with in_valid toggling underneath.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid      = ~in_valid;
      in_index_col1 = 11'd3;
      in_col1       = lanes(52'd77);
    end
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_out_last", out_last, 1'b0);
    chki("rst_out_index", out_index, 11'd0);
    chkd("rst_out_data", out_data, '0);
    chk1("rst_frame_cnt", frame_cnt, 1'b0);
    chk1("rst_drop_err", drop_err, 1'b0);
    chk1("rst_idx_err", idx_err, 1'b0);
    in_valid      = 1'b0;
    in_index_col1 = '0;
    in_col1       = '0;
    rst           = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk1("idle_out_valid", out_valid, 1'b0);
    end

    // Basic two-frame integration; col2 at bin 2 from idx1=1 must be ignored.
    beat(11'd0, 11'd0, lanes(52'd10), '0);
    beat(11'd1, 11'd0, lanes(52'd20), '0);
    beat(11'd2, 11'd3, lanes(52'd30), lanes(52'd40));
    chk1("frameA_cnt", frame_cnt, 1'b1);
    beat(11'd0, 11'd0, lanes(52'd11), '0);
    beat(11'd1, 11'd2, lanes(52'd21), lanes(52'd999));
    beat(11'd2, 11'd3, lanes(52'd31), lanes(52'd41));
    check_dump(lanes(52'd11), lanes(52'd21), lanes(52'd31), lanes(52'd41), 0);
    @(negedge clk);
    chk1("post_dump_valid", out_valid, 1'b0);
    chk1("post_dump_last", out_last, 1'b0);
    chkd("post_dump_data_hold", out_data, lanes(52'd41));
    chki("post_dump_index_hold", out_index, 11'd3);

    // Full-scale lanes in bin 3 for both frames; a beat dropped at E2.
    beat(11'd3, 11'd3, max_all, '0);
    chk1("max_frame_cnt", frame_cnt, 1'b1);
    beat(11'd3, 11'd3, max_all, '0);
    check_dump('0, '0, '0, max_all, 2);
    chk1("drop_err_set", drop_err, 1'b1);
    chk1("idx_err_clean", idx_err, 1'b0);

    // Next period; its first beat is accepted at E5.
    beat(11'd2, 11'd2, lanes(52'd5), '0);
    chk1("drop_err_sticky", drop_err, 1'b1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk1("drop_err_cleared", drop_err, 1'b0);
    beat(11'd7, 11'd7, lanes(52'd5), lanes(52'd5));
    chk1("bad_idx_err", idx_err, 1'b1);
    chk1("bad_idx_no_close", frame_cnt, 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk1("idx_err_cleared", idx_err, 1'b0);
    err_clr = 1'b1;
    beat(11'd2, 11'd9, lanes(52'd1), lanes(52'd100));
    err_clr = 1'b0;
    chk1("idx_err_set_wins", idx_err, 1'b1);
    beat(11'd3, 11'd0, lanes(52'd7), lanes(52'd2));
    chk1("p3_frame_cnt", frame_cnt, 1'b1);
    beat(11'd2, 11'd2, lanes(52'd4), '0);
    beat(11'd3, 11'd0, lanes(52'd8), lanes(52'd4));
    // bin2 = (5+1+4 + 3*lane + 1) >> 1, bin0 from col2 only, 50 excluded.
    check_dump(lanes(52'd3), '0, pack4(52'd5, 52'd7, 52'd8, 52'd10), lanes(52'd8), 0);

    // Reset in the second dump cycle, then a fresh period.
    beat(11'd0, 11'd0, lanes(52'd100), '0);
    beat(11'd3, 11'd3, lanes(52'd1), '0);
    beat(11'd0, 11'd0, lanes(52'd100), '0);
    beat(11'd3, 11'd3, lanes(52'd1), '0);
    chk1("p4_latency_valid", out_valid, 1'b0);
    @(negedge clk);
    chk1("p4_first_valid", out_valid, 1'b1);
    chkd("p4_first_data", out_data, lanes(52'd100));
    @(negedge clk);
    chk1("p4_second_valid", out_valid, 1'b1);
    chki("p4_second_index", out_index, 11'd1);
    rst = 1'b1;
    #1;
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk1("mid_rst_last", out_last, 1'b0);
    chki("mid_rst_index", out_index, 11'd0);
    chkd("mid_rst_data", out_data, '0);
    chk1("mid_rst_frame_cnt", frame_cnt, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("after_rst_valid", out_valid, 1'b0);
    beat(11'd1, 11'd1, lanes(52'd40), '0);
    beat(11'd3, 11'd3, lanes(52'd60), '0);
    beat(11'd1, 11'd1, lanes(52'd42), '0);
    beat(11'd3, 11'd3, lanes(52'd62), '0);
    check_dump('0, lanes(52'd41), '0, lanes(52'd61), 0);
    @(negedge clk);
    chk1("final_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/power_accum.md
# power_accum

Downstream consumer of the magnitude-squared stage. It accumulates per-bin power (4 lanes per bin, up to two bins per beat) over 2^FRAMES_LOG2 consecutive frames. It then streams the rounded per-bin average out in bin order and clears each accumulator as it is read. This forms the non-coherent integration step between the power computation and peak/threshold logic.

## Interface
- DATA_WIDTH, 52, width of each input power lane (unsigned)
- INDEX_WIDTH, 11, width of bin index inputs
- NUM_BINS, 16, number of bins held; valid indices 0..NUM_BINS-1
- FRAMES_LOG2, 4, log2 of frames integrated per period (≥1)
- ACC_WIDTH (localparam), DATA_WIDTH+FRAMES_LOG2, accumulator width; cannot overflow

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  beat qualifier (driven by upstream ready pulse)
- in_index_col1  in  INDEX_WIDTH  bin of in_col1
- in_index_col2  in  INDEX_WIDTH  bin of in_col2
- in_col1  in  4×DATA_WIDTH  packed lanes [3:0], unsigned power
- in_col2  in  4×DATA_WIDTH  packed lanes [3:0], unsigned power
- err_clr  in  1  synchronous clear of both sticky error flags
- out_valid  out  1  out_index/out_data valid
- out_last  out  1  high with final bin of a dump
- out_index  out  INDEX_WIDTH  bin being output
- out_data  out  4×DATA_WIDTH  rounded average per lane
- frame_cnt  out  FRAMES_LOG2  frames closed in current period
- drop_err  out  1  sticky: beat arrived during DUMP
- idx_err  out  1  sticky: out-of-range index seen

## Operation
- Storage: acc[NUM_BINS][4] registers, ACC_WIDTH each. Zero after reset.
- States: ACC, DUMP. Reset → ACC.
- ACC, in_valid beat:
  - col1 is accumulated into acc[in_index_col1][lane] += in_col1[lane].
  - col2 is accumulated only if in_index_col1 ≥ 2 and in_index_col2 ≠ in_index_col1. Otherwise col2 is ignored regardless of its data.
  - Any used index ≥ NUM_BINS: that column is skipped and idx_err is set.
- Frame close: an accepted beat whose used in-range index equals NUM_BINS-1.
  - If frame_cnt < 2^FRAMES_LOG2-1: frame_cnt++.
  - Otherwise: the closing beat's data is still accumulated, then state→DUMP with dump_ptr=0.
- DUMP, each cycle, for dump_ptr:
  - out_data[lane] ← (acc[dump_ptr][lane] + 2^(FRAMES_LOG2-1)) >> FRAMES_LOG2. Compute in ACC_WIDTH+1 bits. The result always fits DATA_WIDTH.
  - out_index ← dump_ptr; out_valid ← 1; acc[dump_ptr] ← 0; dump_ptr++.
  - When dump_ptr = NUM_BINS-1: out_last ← 1, frame_cnt ← 0, state → ACC.
- in_valid beats sampled in DUMP are discarded entirely and set drop_err. Accumulators and frame_cnt are unaffected.
- err_clr clears drop_err/idx_err. If a set condition occurs in the same cycle, set wins.
- No backpressure: the block is always accepting in ACC.

## Timing
- Reset values: out_valid 0, out_last 0, out_index 0, out_data 0, frame_cnt 0, drop_err 0, idx_err 0, all acc 0, state ACC. Reset mid-DUMP aborts the dump immediately.
- Accumulation is registered: acc reflects a beat one edge after it is sampled. Back-to-back beats are supported every cycle, including the same bin on consecutive beats.
- The closing beat of the final frame is sampled at edge E0.
  - out_valid is high for exactly NUM_BINS consecutive cycles, following edges E1..E_NUM_BINS, with out_index 0,1,…,NUM_BINS-1.
  - out_last coincides with index NUM_BINS-1.
- Beats sampled at E1..E_NUM_BINS are dropped. The first beat accepted for the new period is at E_NUM_BINS+1.
- out_valid/out_last/out_index/out_data are registered. out_data holds its last value when out_valid=0.

## Test plan
Use NUM_BINS=4, FRAMES_LOG2=1 throughout.
- Reset: assert rst with in_valid toggling → all outputs 0; out_valid stays 0 for 10 cycles after release with no input.
- Basic integration:
  - Frame A beats: (idx1=0, col1=10), (idx1=1, col1=20), (idx1=2, idx2=3, col1=30, col2=40). Frame B is the same with 11/21/31/41.
  - Result → out_data lanes 11, 21, 31, 41 for index 0..3 over 4 consecutive cycles starting one cycle after B's last beat. out_last on index 3; frame_cnt back to 0.
- Col2 gating and saturation-free max:
  - idx1=1 with col2=999 at idx2=2 → bin 2 gets nothing.
  - All lanes 2^52-1 for bin 3 over both frames → out_data 2^52-1.
- Drop during DUMP: beat at idx1=2 (col1=50) sampled at E2 → discarded, drop_err=1. The next period's bin 2 result excludes 50. err_clr pulse → drop_err=0.
- Bad index: idx1=7 with col1=5 → no acc change, no frame close, idx_err=1.
- Reset mid-DUMP: rst asserted during the second out_valid cycle → out_valid 0 immediately. After release, a fresh 2-frame period yields averages of only the new data.
